// File: rtl/partial_perm_unranker.sv
// Sequential K-of-N partial-permutation unranker: accepts a rank (or a step
// request), decodes one slot per cycle, and holds the lexicographic arrangement.
package partial_perm_unranker_pkg;

   function automatic int ppu_falling(input int n, input int k);
      int p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * (n - i);
      return p;
   endfunction

   // Place value of slot j: arrangements of the slots to its right.
   function automatic int ppu_place(input int n, input int k, input int j);
      int p;
      p = 1;
      for (int i = j + 1; i < k; i++) p = p * (n - i);
      return p;
   endfunction

endpackage

module partial_perm_unranker
   import partial_perm_unranker_pkg::*;
#(
   parameter int N = 4,
   parameter int K = 3,
   localparam int TOTAL = ppu_falling(N, K),
   localparam int IDX_W = $clog2(TOTAL),
   localparam int EL_W  = $clog2(N)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_mode,
   input  logic [IDX_W-1:0]          in_index,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [K-1:0][EL_W-1:0]    out_perm,
   output logic                      out_err,
   output logic                      out_wrap,
   output logic [1:0]                dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid may not depend on ready, and in_valid must be held until
   // in_ready is seen.

   localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

   state_t                    state;
   logic [SLOT_W-1:0]         slot;
   logic [31:0]               rem;
   logic [N-1:0]              used;
   logic [IDX_W-1:0]          last_rank;

   logic [31:0]               cap_rank;
   logic                      cap_err;
   logic                      cap_wrap;
   logic [31:0]               sub;
   int                        digit;
   int                        cnt;
   logic [EL_W-1:0]           sel;
   logic [K-1:0][EL_W-1:0]    ident;

   assign in_ready  = (state == IDLE) && !rst;
   assign dbg_state = state;

   always_comb begin
      ident = '0;
      for (int j = 0; j < K; j++) ident[j] = EL_W'(j);
   end

   // Rank to decode for the request currently offered.
   always_comb begin
      cap_rank = '0;
      cap_err  = 1'b0;
      cap_wrap = 1'b0;
      if (in_mode) begin
         if (last_rank == IDX_W'(TOTAL - 1)) begin
            cap_wrap = 1'b1;
         end else begin
            cap_rank = 32'(last_rank) + 32'd1;
         end
      end else begin
         cap_rank = 32'(in_index);
         cap_err  = (cap_rank >= 32'(TOTAL));
      end
   end

   // Digit by compare chain against constant multiples of the slot's place
   // value, then pick the digit-th smallest element still free.
   always_comb begin
      digit = 0;
      sub   = '0;
      sel   = '0;
      cnt   = 0;
      for (int s = 0; s < K; s++) begin
         if (slot == SLOT_W'(s)) begin
            for (int d = 0; d < N - s; d++) begin
               if (rem >= 32'(d * ppu_place(N, K, s))) begin
                  digit = d;
                  sub   = 32'(d * ppu_place(N, K, s));
               end
            end
         end
      end
      for (int e = 0; e < N; e++) begin
         if (!used[e]) begin
            if (cnt == digit) sel = EL_W'(e);
            cnt = cnt + 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         slot      <= '0;
         rem       <= '0;
         used      <= '0;
         last_rank <= IDX_W'(TOTAL - 1);
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_wrap  <= 1'b0;
         out_perm  <= ident;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= DECODE;
                  slot     <= '0;
                  used     <= '0;
                  rem      <= cap_rank;
                  out_perm <= ident;
                  out_err  <= cap_err;
                  out_wrap <= cap_wrap;
                  if (!cap_err) last_rank <= IDX_W'(cap_rank);
               end
            end
            DECODE: begin
               // Error requests still spend K cycles but keep the identity.
               if (!out_err) begin
                  out_perm[slot] <= sel;
                  used[sel]      <= 1'b1;
                  rem            <= rem - sub;
               end
               if (slot == SLOT_W'(K - 1)) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end else begin
                  slot <= slot + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_partial_perm_unranker.sv
// Randomised bench for partial_perm_unranker against a queue-based lexicographic
// unranker, plus exhaustive sweeps of three other parameter sets.
module tb_partial_perm_unranker;

   localparam int MN = 4;
   localparam int MK = 3;
   localparam int MT = 24;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_mode;
   logic [4:0]             in_index;
   logic                   out_valid;
   logic                   out_ready;
   logic [MK-1:0][1:0]     out_perm;
   logic                   out_err;
   logic                   out_wrap;
   logic [1:0]             dbg_state;

   logic [63:0] exp_q[$];
   int          m_last;
   logic [2:0]  sw_done = '0;

   partial_perm_unranker #(.N(MN), .K(MK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_index(in_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_perm(out_perm), .out_err(out_err),
      .out_wrap(out_wrap), .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int npk(input int n, input int k);
      int p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * (n - i);
      return p;
   endfunction

   // Reference: pick digits by division, remove the chosen element from a pool.
   function automatic logic [63:0] unrank(input int n, input int k, input int rank);
      int pool[$];
      int p, d, rr;
      logic [63:0] r;
      r  = '0;
      rr = rank;
      for (int e = 0; e < n; e++) pool.push_back(e);
      for (int j = 0; j < k; j++) begin
         p  = npk(n - j - 1, k - j - 1);
         d  = rr / p;
         rr = rr % p;
         r[j*8 +: 8] = 8'(pool[d]);
         pool.delete(d);
      end
      return r;
   endfunction

   function automatic logic [63:0] ident(input int k);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < k; j++) r[j*8 +: 8] = 8'(j);
      return r;
   endfunction

   function automatic logic [63:0] pack_main(input logic [MK-1:0][1:0] p);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < MK; j++) r[j*8 +: 8] = 8'(p[j]);
      return r;
   endfunction

   task automatic req(input bit mode, input int idx, input int hold);
      int r, lat, t;
      bit err, wrap;
      logic [63:0] exp_p;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); @(negedge clk); t++;
      end
      check("in_ready_wait", in_ready, 1);
      if (mode) begin
         err = 0;
         if (m_last == MT - 1) begin r = 0; wrap = 1; end
         else begin r = m_last + 1; wrap = 0; end
      end else begin
         r = idx; wrap = 0; err = (r >= MT);
      end
      exp_q.push_back(err ? ident(MK) : unrank(MN, MK, r));
      if (!err) m_last = r;
      in_valid = 1'b1; in_mode = mode; in_index = 5'(idx);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; in_mode = 1'($urandom); in_index = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      check("latency", lat, MK + 1);
      exp_p = exp_q.pop_front();
      check("perm", pack_main(out_perm), exp_p);
      check("err", out_err, err);
      check("wrap", out_wrap, wrap);
      check("busy_ready", in_ready, 0);
      repeat (hold) begin
         @(posedge clk); @(negedge clk);
         check("hold_perm", pack_main(out_perm), exp_p);
         check("hold_valid", out_valid, 1);
         check("hold_err", out_err, err);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_ready", in_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_index = '0; out_ready = 1'b0;
      m_last = MT - 1;
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_err", out_err, 0);
      check("rst_out_wrap", out_wrap, 0);
      check("rst_perm", pack_main(out_perm), ident(MK));

      req(0, 0, 0);
      req(0, 7, 0);
      req(0, 23, 0);
      req(0, 30, 0);
      req(1, 0, 0);

      req(0, 0, 0);
      for (int i = 0; i < 24; i++) req(1, 0, 0);

      req(0, 13, 5);

      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'b0; in_index = 5'd5;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 1);
      check("midrst_perm", pack_main(out_perm), ident(MK));
      check("midrst_err", out_err, 0);
      m_last = MT - 1;
      req(1, 0, 0);

      for (int i = 0; i < 40; i++)
         req(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 2));

      for (int t = 0; t < 20000 && sw_done != 3'b111; t++) @(posedge clk);
      check("sweep_done", sw_done, 3'b111);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int NN = (g == 0) ? 5 : ((g == 1) ? 6 : 2);
      localparam int KK = (g == 0) ? 5 : ((g == 1) ? 2 : 1);
      localparam int TT = npk(NN, KK);
      localparam int IW = $clog2(TT);
      localparam int EW = $clog2(NN);

      logic                 sr, iv, ir, om, orr, ov, oe, ow;
      logic [IW-1:0]        ix;
      logic [KK-1:0][EW-1:0] op;
      logic [1:0]           ds;

      partial_perm_unranker #(.N(NN), .K(KK)) u (
         .clk(clk), .rst(sr), .in_valid(iv), .in_ready(ir), .in_mode(om),
         .in_index(ix), .out_valid(ov), .out_ready(orr), .out_perm(op),
         .out_err(oe), .out_wrap(ow), .dbg_state(ds)
      );

      initial begin
         int lat, t;
         logic [63:0] got;
         sr = 1'b1; iv = 1'b0; om = 1'b0; ix = '0; orr = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         sr = 1'b0;
         for (int r = 0; r < TT; r++) begin
            t = 0;
            while (!ir && t < 50) begin
               @(posedge clk); @(negedge clk); t++;
            end
            check("sw_ready", ir, 1);
            iv = 1'b1; ix = IW'(r);
            @(posedge clk); @(negedge clk);
            iv = 1'b0;
            lat = 1;
            while (!ov && lat < 40) begin
               @(posedge clk); @(negedge clk); lat++;
            end
            check("sw_latency", lat, KK + 1);
            got = '0;
            for (int j = 0; j < KK; j++) got[j*8 +: 8] = 8'(op[j]);
            check("sw_perm", got, unrank(NN, KK, r));
            check("sw_err", oe, 0);
            orr = 1'b1;
            @(posedge clk); @(negedge clk);
            orr = 1'b0;
         end
         sw_done[g] = 1'b1;
      end
   end

endmodule
